// File: rtl/interfaz_tx_pkg.sv
// Shared definitions for the ALU -> UART return path: FSM state encodings,
// default data widths and the byte-counter width rule.
package uart_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEND = 2'b01,
      ST_WAIT = 2'b10
   } state_t;

   localparam int DBIT_DEF      = 8;
   localparam int NB_RESULT_DEF = 16;

   // Counter must hold NBYTES (the checksum slot), never narrower than 1 bit
   function automatic int cnt_width(input int nbytes);
      int w;
      w = $clog2(nbytes + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/interfaz_tx_chk.sv
// XOR accumulator for the frame checksum byte. A clear together with an
// enable starts a fresh sum with the incoming byte.
module interfaz_tx_chk #(
   parameter int DBIT = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_clr,
   input  logic            i_en,
   input  logic [DBIT-1:0] i_din,
   output logic [DBIT-1:0] o_chk
);

   logic [DBIT-1:0] r_acc;

   // Accumulate each loaded byte; clear restarts the sum
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= (i_clr ? '0 : r_acc) ^ i_din;
      end else if (i_clr) begin
         r_acc <= '0;
      end
   end

   assign o_chk = r_acc;

endmodule

// File: rtl/interfaz_tx.sv
// Return-path interface ALU -> UART TX. Captures one ALU result and sends it
// LSB byte first, one start pulse per byte, waiting for the TX done tick.
// Optional feature: define INTERFAZ_TX_CHECKSUM_EN to append an XOR checksum
// byte to every frame.
module interfaz_tx
   import uart_defs::*;
#(
   parameter int DBIT      = DBIT_DEF,
   parameter int NB_RESULT = NB_RESULT_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NB_RESULT-1:0] i_result,
   input  logic                 i_result_valid,
   input  logic                 i_tx_done,
   output logic [DBIT-1:0]      o_tx_data,
   output logic                 o_tx_start,
   output logic                 o_busy,
   output logic                 o_drop
);

   localparam int NBYTES = NB_RESULT / DBIT;
   localparam int CW     = cnt_width(NBYTES);

   localparam logic [CW-1:0] CNT_LAST_DATA = CW'(NBYTES - 1);
`ifdef INTERFAZ_TX_CHECKSUM_EN
   // The checksum byte occupies counter slot NBYTES
   localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES);
`else
   localparam logic [CW-1:0] CNT_LAST = CNT_LAST_DATA;
`endif

   state_t                r_state;
   state_t                w_state_next;
   logic [CW-1:0]         r_cnt;
   logic [NB_RESULT-1:0]  r_shift;
   logic [DBIT-1:0]       r_tx_data;
   logic                  r_drop;

   logic                  w_last;
   logic                  w_final_done;
   logic                  w_next_done;
   logic                  w_accept;
   logic                  w_drop;
   logic [NB_RESULT-1:0]  w_shift_nxt;
   logic [DBIT-1:0]       w_next_byte;

   assign w_last       = (r_cnt == CNT_LAST);
   assign w_final_done = (r_state == ST_WAIT) && i_tx_done && w_last;
   assign w_next_done  = (r_state == ST_WAIT) && i_tx_done && !w_last;
   // A result is taken in IDLE, or back-to-back with the frame's final done
   assign w_accept     = i_result_valid && ((r_state == ST_IDLE) || w_final_done);
   assign w_drop       = i_result_valid && !w_accept && (r_state != ST_IDLE);
   assign w_shift_nxt  = r_shift >> DBIT;
   assign w_next_byte  = w_shift_nxt[DBIT-1:0];

`ifdef INTERFAZ_TX_CHECKSUM_EN
   logic            w_chk_en;
   logic [DBIT-1:0] w_chk_din;
   logic [DBIT-1:0] w_chk;

   // Every result byte is folded in as it is loaded into o_tx_data
   assign w_chk_en  = w_accept || (w_next_done && (r_cnt != CNT_LAST_DATA));
   assign w_chk_din = w_accept ? i_result[DBIT-1:0] : w_next_byte;

   interfaz_tx_chk #(
      .DBIT (DBIT)
   ) u_chk (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_accept),
      .i_en  (w_chk_en),
      .i_din (w_chk_din),
      .o_chk (w_chk)
   );
`endif

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (i_result_valid) w_state_next = ST_SEND;
         ST_SEND: w_state_next = ST_WAIT;
         ST_WAIT: begin
            if (i_tx_done) begin
               if (!w_last || i_result_valid) w_state_next = ST_SEND;
               else                           w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      o_tx_start = (r_state == ST_SEND);
      o_busy     = (r_state != ST_IDLE);
   end

   // Byte datapath: capture on accept, advance one byte per non-final done
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt     <= '0;
         r_shift   <= '0;
         r_tx_data <= '0;
         r_drop    <= 1'b0;
      end else begin
         r_drop <= w_drop;
         if (w_accept) begin
            r_cnt     <= '0;
            r_shift   <= i_result;
            r_tx_data <= i_result[DBIT-1:0];
         end else if (w_next_done) begin
            r_cnt   <= r_cnt + 1'b1;
            r_shift <= w_shift_nxt;
`ifdef INTERFAZ_TX_CHECKSUM_EN
            r_tx_data <= (r_cnt == CNT_LAST_DATA) ? w_chk : w_next_byte;
`else
            r_tx_data <= w_next_byte;
`endif
         end
      end
   end

   assign o_tx_data = r_tx_data;
   assign o_drop    = r_drop;

endmodule

// File: tb/tb_interfaz_tx.sv
// Directed self-checking bench for interfaz_tx (DBIT=8, NB_RESULT=16).
// Follows INTERFAZ_TX_CHECKSUM_EN so the same bench covers both builds.
module tb_interfaz_tx;

   logic        clk;
   logic        rst;
   logic [15:0] i_result;
   logic        i_result_valid;
   logic        i_tx_done;
   logic [7:0]  o_tx_data;
   logic        o_tx_start;
   logic        o_busy;
   logic        o_drop;

   int n_tests = 0;
   int n_fail  = 0;

   interfaz_tx #(
      .DBIT      (8),
      .NB_RESULT (16)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_result       (i_result),
      .i_result_valid (i_result_valid),
      .i_tx_done      (i_tx_done),
      .o_tx_data      (o_tx_data),
      .o_tx_start     (o_tx_start),
      .o_busy         (o_busy),
      .o_drop         (o_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [15:0] r);
      i_result       = r;
      i_result_valid = 1'b1;
      step();
      i_result_valid = 1'b0;
   endtask

   task automatic done_pulse();
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
   endtask

   task automatic expect_start(input string tag, input logic [7:0] b);
      check({tag, " start"}, {31'd0, o_tx_start}, 32'd1);
      check({tag, " data"},  {24'd0, o_tx_data},  {24'd0, b});
      check({tag, " busy"},  {31'd0, o_busy},     32'd1);
   endtask

   task automatic expect_idle(input string tag);
      check({tag, " idle start"}, {31'd0, o_tx_start}, 32'd0);
      check({tag, " idle busy"},  {31'd0, o_busy},     32'd0);
   endtask

   initial begin
      rst            = 1'b1;
      i_result       = '0;
      i_result_valid = 1'b0;
      i_tx_done      = 1'b0;

      // 1. Reset with random inputs holds all outputs low
      for (int k = 0; k < 4; k++) begin
         i_result       = 16'($urandom);
         i_result_valid = 1'($urandom);
         i_tx_done      = 1'($urandom);
         step();
         check("rst data",  {24'd0, o_tx_data},  32'd0);
         check("rst start", {31'd0, o_tx_start}, 32'd0);
         check("rst busy",  {31'd0, o_busy},     32'd0);
         check("rst drop",  {31'd0, o_drop},     32'd0);
      end
      i_result_valid = 1'b0;
      i_tx_done      = 1'b0;
      rst            = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         done_pulse();
         expect_idle("done in idle");
      end

      // 2. Basic frame 0xA53C
      accept(16'hA53C);
      expect_start("A53C b0", 8'h3C);
      repeat (8) step();
      check("A53C hold start", {31'd0, o_tx_start}, 32'd0);
      check("A53C hold data",  {24'd0, o_tx_data},  32'h3C);
      check("A53C hold busy",  {31'd0, o_busy},     32'd1);
      done_pulse();
      expect_start("A53C b1", 8'hA5);
      repeat (8) step();
      done_pulse();
`ifdef INTERFAZ_TX_CHECKSUM_EN
      expect_start("A53C chk", 8'h99);
      repeat (3) step();
      done_pulse();
`endif
      expect_idle("A53C end");
      step();

      // 3. Valid during WAIT is dropped, frame unaffected
      accept(16'hA53C);
      expect_start("drop b0", 8'h3C);
      step();
      accept(16'h1234);
      check("drop pulse", {31'd0, o_drop}, 32'd1);
      step();
      check("drop single", {31'd0, o_drop}, 32'd0);
      done_pulse();
      expect_start("drop b1", 8'hA5);
      step();
      done_pulse();
`ifdef INTERFAZ_TX_CHECKSUM_EN
      expect_start("drop chk", 8'h99);
      step();
      done_pulse();
`endif
      expect_idle("drop end");
      step();

      // 4. Back-to-back accept on the final done
      accept(16'hA53C);
      expect_start("b2b b0", 8'h3C);
      step();
      done_pulse();
      expect_start("b2b b1", 8'hA5);
      step();
`ifdef INTERFAZ_TX_CHECKSUM_EN
      done_pulse();
      expect_start("b2b chk", 8'h99);
      step();
`endif
      i_result       = 16'h00FF;
      i_result_valid = 1'b1;
      i_tx_done      = 1'b1;
      step();
      i_result_valid = 1'b0;
      i_tx_done      = 1'b0;
      expect_start("b2b new b0", 8'hFF);
      check("b2b no drop", {31'd0, o_drop}, 32'd0);
      step();
      done_pulse();
      expect_start("b2b new b1", 8'h00);
      step();
      done_pulse();
`ifdef INTERFAZ_TX_CHECKSUM_EN
      expect_start("b2b new chk", 8'hFF);
      step();
      done_pulse();
`endif
      expect_idle("b2b end");
      step();

      // 5. Asynchronous reset while waiting after the first byte
      accept(16'hA53C);
      step();
      rst = 1'b1;
      #1;
      check("arst busy",  {31'd0, o_busy},     32'd0);
      check("arst data",  {24'd0, o_tx_data},  32'd0);
      check("arst start", {31'd0, o_tx_start}, 32'd0);
      step();
      rst = 1'b0;
      step();
      done_pulse();
      expect_idle("arst done");
      accept(16'hBEEF);
      expect_start("BEEF b0", 8'hEF);
      step();
      done_pulse();
      expect_start("BEEF b1", 8'hBE);
      step();
      done_pulse();
`ifdef INTERFAZ_TX_CHECKSUM_EN
      expect_start("BEEF chk", 8'h51);
      step();
      done_pulse();
`endif
      expect_idle("BEEF end");
      step();

      // 6. Done held high: start pulses exactly 2 cycles apart
      i_tx_done = 1'b1;
      accept(16'h0102);
      expect_start("hold b0", 8'h02);
      step();
      check("hold gap0", {31'd0, o_tx_start}, 32'd0);
      step();
      expect_start("hold b1", 8'h01);
      step();
      check("hold gap1", {31'd0, o_tx_start}, 32'd0);
      step();
`ifdef INTERFAZ_TX_CHECKSUM_EN
      expect_start("hold chk", 8'h03);
      step();
      check("hold gap2", {31'd0, o_tx_start}, 32'd0);
      step();
`endif
      expect_idle("hold end");
      i_tx_done = 1'b0;
      step();
      expect_idle("hold settle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
